// File: rtl/lidar_point_reconstructor.sv
// -----------------------------------------------------------------------------
// lidar_point_reconstructor
//
// Rebuilds LiDAR points from an entropy-decoded symbol stream. Each point
// arrives as six symbols (mode, res_x, res_y, res_z, attr_lo, attr_hi).
// Geometry is predicted from the previous one or two points. Attributes are
// raw, delta-coded, or predicted from the average of the last K attribute
// words. A frame holds N_POINTS points and is closed by sym_last.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   sym_valid/sym_ready     symbol handshake; sym_data, sym_last with it
//   pt_valid/pt_ready       point handshake; pt_x/y/z, pt_attr, pt_last with it
//   frame_done              one-cycle pulse at the end of every frame
//   frame_error             valid with frame_done; the frame had an error
//   err_count               saturating count of errored frames
// -----------------------------------------------------------------------------
module lidar_point_reconstructor #(
  parameter int N_POINTS          = 4,
  parameter int SYMBOL_WIDTH      = 16,
  parameter int COORD_WIDTH       = 32,
  parameter int K                 = 4,
  parameter int SYMBOLS_PER_POINT = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic [SYMBOL_WIDTH-1:0]       sym_data,
  input  logic                          sym_last,
  output logic                          pt_valid,
  input  logic                          pt_ready,
  output logic signed [COORD_WIDTH-1:0] pt_x,
  output logic signed [COORD_WIDTH-1:0] pt_y,
  output logic signed [COORD_WIDTH-1:0] pt_z,
  output logic [2*SYMBOL_WIDTH-1:0]     pt_attr,
  output logic                          pt_last,
  output logic                          frame_done,
  output logic                          frame_error,
  output logic [7:0]                    err_count
);

  localparam int AW   = 2 * SYMBOL_WIDTH;
  localparam int KW   = $clog2(K);
  localparam int SUMW = AW + KW;
  localparam int PW   = $clog2(N_POINTS);
  localparam logic [PW-1:0] LAST_PT   = PW'(N_POINTS - 1);
  localparam logic [2:0]    LAST_SLOT = 3'(SYMBOLS_PER_POINT - 1);

  // ST_DONE is the single frame-end cycle that carries frame_done.
  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_RECON   = 3'd1;
  localparam logic [2:0] ST_EMIT    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [PW-1:0]           point_idx_q, point_idx_d;
  logic [2:0]              sym_idx_q, sym_idx_d;
  logic                    last_q, last_d;     // slot 5 of this point carried sym_last
  logic                    err_q, err_d;       // current frame is in error
  logic [7:0]              err_count_q, err_count_d;

  logic [3:0]              mode_q;
  logic [SYMBOL_WIDTH-1:0] res_sym_q [3];
  logic [SYMBOL_WIDTH-1:0] attr_lo_q, attr_hi_q;

  logic [COORD_WIDTH-1:0]  p1_q [3], p1_d [3];
  logic [COORD_WIDTH-1:0]  p2_q [3], p2_d [3];
  logic [COORD_WIDTH-1:0]  pt_q [3], pt_d [3];
  logic [AW-1:0]           hist_q [K], hist_d [K];  // newest raw attribute word at [0]
  logic [AW-1:0]           attr_q, attr_d;

  logic [COORD_WIDTH-1:0]  res [3];
  logic [COORD_WIDTH-1:0]  p_new [3];
  logic [AW-1:0]           raw_attr, attr_new;
  logic [SUMW-1:0]         hist_sum;
  logic [1:0]              gm, am;
  logic                    mode_bad, collect_fire, drain_fire;

  assign collect_fire = sym_valid && (state_q == ST_COLLECT);
  assign drain_fire   = sym_valid && (state_q == ST_DRAIN);

  // Prediction datapath, evaluated while in RECON.
  always_comb begin
    gm       = mode_q[1:0];
    am       = mode_q[3:2];
    mode_bad = (gm == 2'd3) || (am == 2'd3);
    raw_attr = {attr_hi_q, attr_lo_q};
    // The extra KW bits hold the full sum so the average is exact before it wraps.
    hist_sum = '0;
    for (int i = 0; i < K; i++) hist_sum = hist_sum + SUMW'(hist_q[i]);
    for (int a = 0; a < 3; a++) begin
      res[a] = COORD_WIDTH'($signed(res_sym_q[a]));
      case (gm)
        2'd1:    p_new[a] = p1_q[a] + res[a];
        2'd2:    p_new[a] = (p1_q[a] << 1) - p2_q[a] + res[a];
        default: p_new[a] = res[a];
      endcase
    end
    case (am)
      2'd1:    attr_new = hist_q[0] + raw_attr;
      2'd2:    attr_new = hist_sum[KW +: AW] + raw_attr;
      default: attr_new = raw_attr;
    endcase
  end

  // NOTE: every next-state signal takes its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    point_idx_d = point_idx_q;
    sym_idx_d   = sym_idx_q;
    last_d      = last_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    pt_d        = pt_q;
    hist_d      = hist_q;
    attr_d      = attr_q;
    case (state_q)
      ST_COLLECT: begin
        if (collect_fire) begin
          sym_idx_d = sym_idx_q + 3'd1;
          if (sym_idx_q == LAST_SLOT) begin
            last_d = sym_last;
            if (sym_last && (point_idx_q != LAST_PT)) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RECON;
            end
          end else if (sym_last) begin
            // Early sym_last: the frame terminator is already consumed, so skip DRAIN.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RECON: begin
        if (mode_bad) begin
          err_d   = 1'b1;
          state_d = last_q ? ST_DONE : ST_DRAIN;
        end else begin
          pt_d      = p_new;
          attr_d    = attr_new;
          p2_d      = p1_q;
          p1_d      = p_new;
          hist_d[0] = raw_attr;
          for (int i = 1; i < K; i++) hist_d[i] = hist_q[i-1];
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (pt_ready) begin
          point_idx_d = point_idx_q + PW'(1);
          sym_idx_d   = 3'd0;
          if (point_idx_q == LAST_PT) begin
            if (last_q) begin
              state_d = ST_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_fire && sym_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        point_idx_d = '0;
        sym_idx_d   = 3'd0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        for (int a = 0; a < 3; a++) begin
          p1_d[a] = '0;
          p2_d[a] = '0;
        end
        for (int i = 0; i < K; i++) hist_d[i] = '0;
        state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      point_idx_q <= '0;
      sym_idx_q   <= 3'd0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
      mode_q      <= 4'd0;
      attr_lo_q   <= '0;
      attr_hi_q   <= '0;
      attr_q      <= '0;
      // NOTE: the history arrays are reset because a new frame must predict from zero.
      for (int a = 0; a < 3; a++) begin
        res_sym_q[a] <= '0;
        p1_q[a]      <= '0;
        p2_q[a]      <= '0;
        pt_q[a]      <= '0;
      end
      for (int i = 0; i < K; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      point_idx_q <= point_idx_d;
      sym_idx_q   <= sym_idx_d;
      last_q      <= last_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      pt_q        <= pt_d;
      hist_q      <= hist_d;
      attr_q      <= attr_d;
      if (collect_fire) begin
        case (sym_idx_q)
          3'd0:    mode_q       <= sym_data[3:0];
          3'd1:    res_sym_q[0] <= sym_data;
          3'd2:    res_sym_q[1] <= sym_data;
          3'd3:    res_sym_q[2] <= sym_data;
          3'd4:    attr_lo_q    <= sym_data;
          3'd5:    attr_hi_q    <= sym_data;
          default: ;
        endcase
      end
    end
  end

  assign sym_ready   = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  assign pt_valid    = (state_q == ST_EMIT);
  assign pt_x        = pt_q[0];
  assign pt_y        = pt_q[1];
  assign pt_z        = pt_q[2];
  assign pt_attr     = attr_q;
  assign pt_last     = pt_valid && (point_idx_q == LAST_PT);
  assign frame_done  = (state_q == ST_DONE);
  assign frame_error = frame_done && err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_lidar_point_reconstructor.sv
// -----------------------------------------------------------------------------
// Directed testbench for lidar_point_reconstructor (N_POINTS=4, K=4).
// Symbols are driven at negedges. A negedge monitor collects every accepted
// point and every frame_done pulse. Each scenario compares the collected data
// against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_lidar_point_reconstructor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [15:0] sym_data = '0;
  logic        sym_last = 1'b0;
  logic        pt_valid;
  logic        pt_ready = 1'b1;
  logic [31:0] pt_x, pt_y, pt_z, pt_attr;
  logic        pt_last, frame_done, frame_error;
  logic [7:0]  err_count;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] x, y, z, attr;
    logic        last;
  } pt_t;

  pt_t  got_q[$];
  pt_t  exp_q[$];
  logic ferr_q[$];

  always #5 clk = ~clk;

  lidar_point_reconstructor #(
    .N_POINTS(4), .SYMBOL_WIDTH(16), .COORD_WIDTH(32), .K(4), .SYMBOLS_PER_POINT(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_attr(pt_attr), .pt_last(pt_last),
    .frame_done(frame_done), .frame_error(frame_error), .err_count(err_count)
  );

  // Monitor: the values seen at a negedge are those handshaken at the next posedge.
  always @(negedge clk) begin
    if (rst_n && pt_valid && pt_ready) got_q.push_back('{pt_x, pt_y, pt_z, pt_attr, pt_last});
    if (rst_n && frame_done) begin
      done_cnt++;
      ferr_q.push_back(frame_error);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the symbol's handshake.
  task automatic send_sym(input logic [15:0] d, input logic l);
    int n = 0;
    sym_valid = 1'b1;
    sym_data  = d;
    sym_last  = l;
    while (sym_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("sym_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic send_point(input logic [15:0] mode, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic [15:0] lo, input logic [15:0] hi,
                            input logic last);
    send_sym(mode, 1'b0);
    send_sym(x, 1'b0);
    send_sym(y, 1'b0);
    send_sym(z, 1'b0);
    send_sym(lo, 1'b0);
    send_sym(hi, last);
  endtask

  task automatic exp_pt(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [31:0] attr, input logic last);
    exp_q.push_back('{x, y, z, attr, last});
  endtask

  task automatic wait_done(input int base, input logic exp_err);
    int n = 0;
    while (done_cnt == base && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 32'(done_cnt - base), 32'd1);
    repeat (3) @(negedge clk);
    check("frame_done_single", 32'(done_cnt - base), 32'd1);
    if (ferr_q.size() > 0) check("frame_error", 32'(ferr_q[$]), 32'(exp_err));
  endtask

  task automatic compare_points(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_p%0d_x", tag, i), got_q[i].x, exp_q[i].x);
      check($sformatf("%s_p%0d_y", tag, i), got_q[i].y, exp_q[i].y);
      check($sformatf("%s_p%0d_z", tag, i), got_q[i].z, exp_q[i].z);
      check($sformatf("%s_p%0d_attr", tag, i), got_q[i].attr, exp_q[i].attr);
      check($sformatf("%s_p%0d_last", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Clean gm1 frame with x residual 5: checks that geometry history starts at zero.
  task automatic clean_gm1_frame(input string tag);
    int base = done_cnt;
    for (int i = 0; i < 4; i++) send_point(16'h0001, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, i == 3);
    for (int i = 0; i < 4; i++) exp_pt(32'(5 * (i + 1)), 32'd0, 32'd0, 32'd0, i == 3);
    wait_done(base, 1'b0);
    compare_points(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int stall_bad;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pt_valid", 32'(pt_valid), 32'd0);
    check("rst_sym_ready", 32'(sym_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_pt_x", pt_x, 32'd0);

    // gm0/am0: points equal the residuals, -2 sign-extends.
    base = done_cnt;
    for (int i = 0; i < 4; i++) send_point(16'h0000, 16'd10, 16'hFFFE, 16'd3, 16'h1234, 16'h00FF, i == 3);
    for (int i = 0; i < 4; i++) exp_pt(32'd10, 32'hFFFF_FFFE, 32'd3, 32'h00FF_1234, i == 3);
    wait_done(base, 1'b0);
    compare_points("gm0");

    // gm1 accumulates: 5, 10, 15, 20.
    clean_gm1_frame("gm1");

    // gm2 linear prediction with x residuals 1,1,0,0: 1, 3, 5, 7.
    base = done_cnt;
    send_point(16'h0002, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    send_point(16'h0002, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    send_point(16'h0002, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    send_point(16'h0002, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    exp_pt(32'd1, 32'd0, 32'd0, 32'd0, 1'b0);
    exp_pt(32'd3, 32'd0, 32'd0, 32'd0, 1'b0);
    exp_pt(32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
    exp_pt(32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_done(base, 1'b0);
    compare_points("gm2");

    // am2 history average with raw A=8: 8, 10, 12, 14.
    base = done_cnt;
    for (int i = 0; i < 4; i++) send_point(16'h0008, 16'd0, 16'd0, 16'd0, 16'd8, 16'd0, i == 3);
    exp_pt(32'd0, 32'd0, 32'd0, 32'd8, 1'b0);
    exp_pt(32'd0, 32'd0, 32'd0, 32'd10, 1'b0);
    exp_pt(32'd0, 32'd0, 32'd0, 32'd12, 1'b0);
    exp_pt(32'd0, 32'd0, 32'd0, 32'd14, 1'b1);
    wait_done(base, 1'b0);
    compare_points("am2");

    // am1 delta (including a 32-bit wrap) and res_z=0x8000 sign extension.
    base = done_cnt;
    send_point(16'h0000, 16'd0, 16'd0, 16'h8000, 16'h0005, 16'h0001, 1'b0);
    send_point(16'h0004, 16'd0, 16'd0, 16'h8000, 16'h0003, 16'h0000, 1'b0);
    send_point(16'h0000, 16'd0, 16'd0, 16'h8000, 16'hFFFF, 16'hFFFF, 1'b0);
    send_point(16'h0004, 16'd0, 16'd0, 16'h8000, 16'h0002, 16'h0000, 1'b1);
    exp_pt(32'd0, 32'd0, 32'hFFFF_8000, 32'h0001_0005, 1'b0);
    exp_pt(32'd0, 32'd0, 32'hFFFF_8000, 32'h0001_0008, 1'b0);
    exp_pt(32'd0, 32'd0, 32'hFFFF_8000, 32'hFFFF_FFFF, 1'b0);
    exp_pt(32'd0, 32'd0, 32'hFFFF_8000, 32'h0000_0001, 1'b1);
    wait_done(base, 1'b0);
    compare_points("am1");

    // Back-pressure: point 1 held for 10 cycles with a symbol pending.
    base = done_cnt;
    send_point(16'h0001, 16'd5, 16'd0, 16'd0, 16'h00AA, 16'd0, 1'b0);
    send_point(16'h0001, 16'd5, 16'd0, 16'd0, 16'h00AA, 16'd0, 1'b0);
    pt_ready = 1'b0;
    check("lat_recon_no_valid", 32'(pt_valid), 32'd0);
    @(negedge clk);
    check("lat_emit_valid", 32'(pt_valid), 32'd1);
    sym_valid = 1'b1;
    sym_data  = 16'h0001;
    sym_last  = 1'b0;
    stall_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (pt_valid !== 1'b1 || pt_x !== 32'd10 || pt_attr !== 32'h0000_00AA || sym_ready !== 1'b0)
        stall_bad++;
      @(negedge clk);
    end
    check("stall_stable", 32'(stall_bad), 32'd0);
    @(posedge clk);
    #1 pt_ready = 1'b1;
    send_point(16'h0001, 16'd5, 16'd0, 16'd0, 16'h00AA, 16'd0, 1'b0);
    send_point(16'h0001, 16'd5, 16'd0, 16'd0, 16'h00AA, 16'd0, 1'b1);
    for (int i = 0; i < 4; i++) exp_pt(32'(5 * (i + 1)), 32'd0, 32'd0, 32'h0000_00AA, i == 3);
    wait_done(base, 1'b0);
    compare_points("stall");

    // gm=3 on point 2: two points out, the rest drained, history cleared afterwards.
    base = done_cnt;
    send_point(16'h0001, 16'd7, 16'd0, 16'd0, 16'd1, 16'd0, 1'b0);
    send_point(16'h0001, 16'd7, 16'd0, 16'd0, 16'd1, 16'd0, 1'b0);
    send_point(16'h0003, 16'd7, 16'd0, 16'd0, 16'd1, 16'd0, 1'b0);
    send_point(16'h0001, 16'd7, 16'd0, 16'd0, 16'd1, 16'd0, 1'b1);
    exp_pt(32'd7, 32'd0, 32'd0, 32'd1, 1'b0);
    exp_pt(32'd14, 32'd0, 32'd0, 32'd1, 1'b0);
    wait_done(base, 1'b1);
    compare_points("bad_gm");
    check("bad_gm_err_count", 32'(err_count), 32'd1);
    clean_gm1_frame("after_bad_gm");

    // sym_last on slot 3 of point 1: immediate error, no drain.
    base = done_cnt;
    send_point(16'h0000, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 1'b0);
    send_sym(16'h0000, 1'b0);
    send_sym(16'd1, 1'b0);
    send_sym(16'd2, 1'b0);
    send_sym(16'd3, 1'b1);
    exp_pt(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    wait_done(base, 1'b1);
    compare_points("early_last");
    check("early_last_err_count", 32'(err_count), 32'd2);

    // Last point without sym_last: still emitted, then drain to the next sym_last.
    base = done_cnt;
    for (int i = 0; i < 4; i++) send_point(16'h0000, 16'(i), 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    send_sym(16'h1234, 1'b1);
    for (int i = 0; i < 4; i++) exp_pt(32'(i), 32'd0, 32'd0, 32'd0, i == 3);
    wait_done(base, 1'b1);
    compare_points("missing_last");
    check("missing_last_err_count", 32'(err_count), 32'd3);

    // Saturation: 252 more errors reach 255, five further errors keep it there.
    base = done_cnt;
    for (int k = 0; k < 252; k++) send_sym(16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    check("sat_reach_255", 32'(err_count), 32'd255);
    for (int k = 0; k < 5; k++) send_sym(16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    check("sat_hold_255", 32'(err_count), 32'd255);
    check("sat_frames", 32'(done_cnt - base), 32'd257);

    // Reset while a point is waiting in EMIT.
    base = done_cnt;
    send_point(16'h0001, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    pt_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_valid", 32'(pt_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pt_valid", 32'(pt_valid), 32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    check("rst_mid_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    pt_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - base), 32'd0);
    check("rst_mid_no_point", 32'(got_q.size()), 32'd0);
    check("rst_mid_sym_ready", 32'(sym_ready), 32'd1);
    got_q.delete();
    clean_gm1_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
